// File: rtl/dev_timer_pkg.sv
// Shared definitions for the DEVn programmable-interval timer responder.
package dev_timer_pkg;

  localparam int unsigned COUNT_W    = 32;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned BUS_W      = 32;

  localparam logic [BUS_W-1:0] REG_CTRL     = 32'h0000_0000;
  localparam logic [BUS_W-1:0] REG_COUNT    = 32'h0000_0004;
  localparam logic [BUS_W-1:0] REG_COMPARE  = 32'h0000_0008;
  localparam logic [BUS_W-1:0] REG_STATUS   = 32'h0000_000C;
  localparam logic [BUS_W-1:0] REG_PRESCALE = 32'h0000_0010;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD = 2;
  localparam int unsigned CTRL_CLR         = 3;

  localparam int unsigned STATUS_MATCH    = 0;
  localparam int unsigned STATUS_IRQ_PEND = 1;

  typedef enum logic {R_IDLE, R_PEND} resp_state_t;
  typedef enum logic {I_IDLE, I_PEND} irq_state_t;

  // Registers are word-aligned; the two low byte-address bits never select anything.
  function automatic logic [BUS_W-1:0] wordAlign(input logic [BUS_W-1:0] addr);
    return addr & ~BUS_W'(3);
  endfunction

endpackage

// File: rtl/dev_timer_counter.sv
// Prescaler plus 32-bit COUNT with compare/match event; clear and load override the tick update.
module dev_timer_counter
  import dev_timer_pkg::*;
(
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iEnable,
  input  logic                  iAutoReload,
  input  logic [PRESCALE_W-1:0] iPrescale,
  input  logic [COUNT_W-1:0]    iCompare,
  input  logic                  iClear,
  input  logic                  iLoad,
  input  logic [COUNT_W-1:0]    iLoadValue,
  output logic [COUNT_W-1:0]    oCount,
  output logic                  oMatch_c
);

  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick_c;

  assign tick_c   = iEnable && (prescaler == iPrescale);
  assign oMatch_c = tick_c && (oCount == iCompare);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      prescaler <= '0;
      oCount    <= '0;
    end else if (iRESET_SYNC) begin
      prescaler <= '0;
      oCount    <= '0;
    end else begin
      if (iClear) begin
        prescaler <= '0;
      end else if (iEnable) begin
        prescaler <= tick_c ? '0 : prescaler + PRESCALE_W'(1);
      end

      // A bus write to COUNT takes precedence over the tick in the same cycle.
      if (iClear) begin
        oCount <= '0;
      end else if (iLoad) begin
        oCount <= iLoadValue;
      end else if (tick_c) begin
        oCount <= (oMatch_c && iAutoReload) ? '0 : oCount + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dev_timer_responder.sv
// DEVn responder hosting a prescaled compare/match timer: address decode, register bank,
// read-response handshake and level IRQ held until acknowledged.
module dev_timer_responder
  import dev_timer_pkg::*;
#(
  parameter logic [PRESCALE_W-1:0] P_PRESCALE_RST = 16'h0000,
  parameter logic [COUNT_W-1:0]    P_COMPARE_RST  = 32'hFFFF_FFFF
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iBUS_REQ,
  output logic             oBUS_BUSY,
  input  logic             iBUS_RW,
  input  logic [BUS_W-1:0] iBUS_ADDR,
  input  logic [BUS_W-1:0] iBUS_DATA,
  output logic             oBUS_REQ,
  input  logic             iBUS_BUSY,
  output logic [BUS_W-1:0] oBUS_DATA,
  output logic             oIRQ,
  input  logic             iIRQ_ACK
);

  resp_state_t           respState;
  irq_state_t            irqState;
  logic                  ctrlEn;
  logic                  ctrlIrqEn;
  logic                  ctrlAutoReload;
  logic [COUNT_W-1:0]    compareReg;
  logic [PRESCALE_W-1:0] prescaleReg;
  logic                  matchFlag;
  logic [COUNT_W-1:0]    count;
  logic                  match_c;

  logic [BUS_W-1:0] regAddr_c;
  logic             wrAcc_c;
  logic             rdAcc_c;
  logic             wrCtrl_c;
  logic             wrCount_c;
  logic             wrCompare_c;
  logic             wrStatus_c;
  logic             wrPrescale_c;
  logic             irqRaise_c;
  logic [BUS_W-1:0] readData_c;

  assign regAddr_c    = wordAlign(iBUS_ADDR);
  assign wrAcc_c      = iBUS_REQ && iBUS_RW && (respState == R_IDLE);
  assign rdAcc_c      = iBUS_REQ && !iBUS_RW && (respState == R_IDLE);
  assign wrCtrl_c     = wrAcc_c && (regAddr_c == REG_CTRL);
  assign wrCount_c    = wrAcc_c && (regAddr_c == REG_COUNT);
  assign wrCompare_c  = wrAcc_c && (regAddr_c == REG_COMPARE);
  assign wrStatus_c   = wrAcc_c && (regAddr_c == REG_STATUS);
  assign wrPrescale_c = wrAcc_c && (regAddr_c == REG_PRESCALE);
  assign irqRaise_c   = match_c && ctrlIrqEn;

  assign oBUS_BUSY = (respState == R_PEND);
  assign oBUS_REQ  = (respState == R_PEND) && !iBUS_BUSY;
  assign oIRQ      = (irqState == I_PEND);

  dev_timer_counter uCounter (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iEnable     (ctrlEn),
    .iAutoReload (ctrlAutoReload),
    .iPrescale   (prescaleReg),
    .iCompare    (compareReg),
    .iClear      (wrCtrl_c && iBUS_DATA[CTRL_CLR]),
    .iLoad       (wrCount_c),
    .iLoadValue  (iBUS_DATA),
    .oCount      (count),
    .oMatch_c    (match_c)
  );

  // Read mux; unmapped addresses return zero but still get a response.
  always_comb begin
    readData_c = '0;
    case (regAddr_c)
      REG_CTRL: begin
        readData_c[CTRL_EN]          = ctrlEn;
        readData_c[CTRL_IRQ_EN]      = ctrlIrqEn;
        readData_c[CTRL_AUTO_RELOAD] = ctrlAutoReload;
      end
      REG_COUNT:    readData_c = count;
      REG_COMPARE:  readData_c = compareReg;
      REG_STATUS: begin
        readData_c[STATUS_MATCH]    = matchFlag;
        readData_c[STATUS_IRQ_PEND] = (irqState == I_PEND);
      end
      REG_PRESCALE: readData_c = BUS_W'(prescaleReg);
      default:      readData_c = '0;
    endcase
  end

  // Register bank; a fresh match wins over a write-1-to-clear of MATCH.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ctrlEn         <= 1'b0;
      ctrlIrqEn      <= 1'b0;
      ctrlAutoReload <= 1'b0;
      compareReg     <= P_COMPARE_RST;
      prescaleReg    <= P_PRESCALE_RST;
      matchFlag      <= 1'b0;
    end else if (iRESET_SYNC) begin
      ctrlEn         <= 1'b0;
      ctrlIrqEn      <= 1'b0;
      ctrlAutoReload <= 1'b0;
      compareReg     <= P_COMPARE_RST;
      prescaleReg    <= P_PRESCALE_RST;
      matchFlag      <= 1'b0;
    end else begin
      if (wrCtrl_c) begin
        ctrlEn         <= iBUS_DATA[CTRL_EN];
        ctrlIrqEn      <= iBUS_DATA[CTRL_IRQ_EN];
        ctrlAutoReload <= iBUS_DATA[CTRL_AUTO_RELOAD];
      end
      if (wrCompare_c) begin
        compareReg <= iBUS_DATA;
      end
      if (wrPrescale_c) begin
        prescaleReg <= iBUS_DATA[PRESCALE_W-1:0];
      end
      if (match_c) begin
        matchFlag <= 1'b1;
      end else if (wrStatus_c && iBUS_DATA[STATUS_MATCH]) begin
        matchFlag <= 1'b0;
      end
    end
  end

  // Read response: data captured on accept and held until the core takes it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      respState <= R_IDLE;
      oBUS_DATA <= '0;
    end else if (iRESET_SYNC) begin
      respState <= R_IDLE;
      oBUS_DATA <= '0;
    end else if (respState == R_IDLE) begin
      if (rdAcc_c) begin
        respState <= R_PEND;
        oBUS_DATA <= readData_c;
      end
    end else if (!iBUS_BUSY) begin
      respState <= R_IDLE;
    end
  end

  // Level IRQ; matches while pending are coalesced and a simultaneous match outranks ACK.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      irqState <= I_IDLE;
    end else if (iRESET_SYNC) begin
      irqState <= I_IDLE;
    end else if (irqState == I_IDLE) begin
      if (irqRaise_c) begin
        irqState <= I_PEND;
      end
    end else if (iIRQ_ACK && !irqRaise_c) begin
      irqState <= I_IDLE;
    end
  end

endmodule

// File: tb/tb_dev_timer_responder.sv
// Directed plus randomized bench for dev_timer_responder against a cycle-level reference model.
module tb_dev_timer_responder;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iBUS_REQ;
  logic        oBUS_BUSY;
  logic        iBUS_RW;
  logic [31:0] iBUS_ADDR;
  logic [31:0] iBUS_DATA;
  logic        oBUS_REQ;
  logic        iBUS_BUSY;
  logic [31:0] oBUS_DATA;
  logic        oIRQ;
  logic        iIRQ_ACK;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        mEn, mIrqEn, mAr, mMatch, mIrq, mPend;
  logic [31:0] mCount, mCompare, mData;
  logic [15:0] mPrescale, mPsc;

  dev_timer_responder dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iBUS_REQ    (iBUS_REQ),
    .oBUS_BUSY   (oBUS_BUSY),
    .iBUS_RW     (iBUS_RW),
    .iBUS_ADDR   (iBUS_ADDR),
    .iBUS_DATA   (iBUS_DATA),
    .oBUS_REQ    (oBUS_REQ),
    .iBUS_BUSY   (iBUS_BUSY),
    .oBUS_DATA   (oBUS_DATA),
    .oIRQ        (oIRQ),
    .iIRQ_ACK    (iIRQ_ACK)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mEn = 0; mIrqEn = 0; mAr = 0; mMatch = 0; mIrq = 0; mPend = 0;
    mCount = 0; mCompare = 32'hFFFF_FFFF; mData = 0; mPrescale = 0; mPsc = 0;
  endtask

  function automatic logic [31:0] mRead(input logic [31:0] a);
    case (a & ~32'h3)
      32'h00:  return {29'b0, mAr, mIrqEn, mEn};
      32'h04:  return mCount;
      32'h08:  return mCompare;
      32'h0C:  return {30'b0, mIrq, mMatch};
      32'h10:  return {16'b0, mPrescale};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic predTick();
    return mEn && (mPsc == mPrescale);
  endfunction

  function automatic logic predMatch();
    return predTick() && (mCount == mCompare);
  endfunction

  // One clock: check the combinational response, advance the model by the timer rules, check outputs.
  task automatic cycle();
    logic        tick, ev, raise, acc;
    logic        nEn, nIrqEn, nAr, nMatch, nIrq, nPend;
    logic [31:0] nCount, nCompare, nData;
    logic [15:0] nPrescale, nPsc;
    logic        syncRst;
    #1;
    chk("busReq", 32'(oBUS_REQ), 32'(mPend && !iBUS_BUSY));
    tick  = predTick();
    ev    = predMatch();
    raise = ev && mIrqEn;
    nEn = mEn; nIrqEn = mIrqEn; nAr = mAr; nCompare = mCompare; nPrescale = mPrescale;
    nPsc   = !mEn ? mPsc : (tick ? 16'd0 : mPsc + 16'd1);
    nCount = !tick ? mCount : ((ev && mAr) ? 32'd0 : mCount + 32'd1);
    nMatch = mMatch || ev;
    nIrq   = mIrq ? !(iIRQ_ACK && !raise) : raise;
    acc    = iBUS_REQ && !mPend;
    nPend  = mPend;
    nData  = mData;
    if (acc && !iBUS_RW) begin
      nPend = 1;
      nData = mRead(iBUS_ADDR);
    end else if (mPend && !iBUS_BUSY) begin
      nPend = 0;
    end
    if (acc && iBUS_RW) begin
      case (iBUS_ADDR & ~32'h3)
        32'h00: begin
          nEn = iBUS_DATA[0]; nIrqEn = iBUS_DATA[1]; nAr = iBUS_DATA[2];
          if (iBUS_DATA[3]) begin nPsc = 0; nCount = 0; end
        end
        32'h04: nCount = iBUS_DATA;
        32'h08: nCompare = iBUS_DATA;
        32'h0C: if (iBUS_DATA[0] && !ev) nMatch = 0;
        32'h10: nPrescale = iBUS_DATA[15:0];
        default: ;
      endcase
    end
    syncRst = iRESET_SYNC;
    @(posedge iCLOCK);
    #1;
    mEn = nEn; mIrqEn = nIrqEn; mAr = nAr; mCompare = nCompare; mPrescale = nPrescale;
    mPsc = nPsc; mCount = nCount; mMatch = nMatch; mIrq = nIrq; mPend = nPend; mData = nData;
    if (syncRst) modelReset();
    chk("busBusy", 32'(oBUS_BUSY), 32'(mPend));
    chk("irq", 32'(oIRQ), 32'(mIrq));
    if (mPend) chk("busData", oBUS_DATA, mData);
  endtask

  task automatic idle();
    iBUS_REQ = 0; iBUS_RW = 0; iIRQ_ACK = 0; iRESET_SYNC = 0;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    iBUS_REQ = 1; iBUS_RW = 1; iBUS_ADDR = a; iBUS_DATA = d;
    cycle();
    idle();
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] exp, input string tag);
    iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = a; iBUS_BUSY = 0;
    cycle();
    idle();
    chk(tag, oBUS_DATA, exp);
    cycle();
  endtask

  initial begin
    logic [31:0] addrTab [6];
    logic [31:0] held, a;
    addrTab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h40};
    inRESET = 0; iBUS_ADDR = 0; iBUS_DATA = 0; iBUS_BUSY = 0;
    idle();
    modelReset();
    #12;
    chk("rstBusy", 32'(oBUS_BUSY), 0);
    chk("rstReq", 32'(oBUS_REQ), 0);
    chk("rstData", oBUS_DATA, 0);
    chk("rstIrq", 32'(oIRQ), 0);
    @(posedge iCLOCK); #1;
    inRESET = 1;

    // 1: COMPARE reset value, single-cycle busy
    iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = 32'h08;
    cycle();
    idle();
    chk("t1Data", oBUS_DATA, 32'hFFFF_FFFF);
    chk("t1Busy", 32'(oBUS_BUSY), 1);
    cycle();
    chk("t1BusyDrop", 32'(oBUS_BUSY), 0);

    // 2: stalled response path
    iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = 32'h04; iBUS_BUSY = 1;
    cycle();
    idle();
    held = oBUS_DATA;
    chk("t2Data", held, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2Stable", oBUS_DATA, held);
    end
    iBUS_BUSY = 0;
    cycle();
    chk("t2Done", 32'(oBUS_BUSY), 0);

    // 3: prescaled auto-reload match raises IRQ
    busWrite(32'h10, 32'd2);
    busWrite(32'h08, 32'd3);
    busWrite(32'h00, 32'hF);
    for (int i = 0; i < 40 && !oIRQ; i++) cycle();
    chk("t3IrqRise", 32'(oIRQ), 1);
    busRead(32'h0C, 32'h3, "t3Status");
    busRead(32'h00, 32'h7, "t3Ctrl");

    // 4: ACK coinciding with a new match keeps IRQ; lone ACK clears it
    for (int i = 0; i < 40 && !predMatch(); i++) cycle();
    chk("t4Aligned", 32'(predMatch()), 1);
    iIRQ_ACK = 1;
    cycle();
    iIRQ_ACK = 0;
    chk("t4Held", 32'(oIRQ), 1);
    iIRQ_ACK = 1;
    cycle();
    iIRQ_ACK = 0;
    chk("t4Clear", 32'(oIRQ), 0);

    // 5: unmapped address
    busRead(32'h40, 32'h0, "t5Read");
    busWrite(32'h40, 32'hDEAD_BEEF);
    chk("t5NoResp", 32'(oBUS_BUSY), 0);
    busRead(32'h08, 32'd3, "t5Compare");
    busRead(32'h13, 32'd2, "t5Prescale");

    // 6: COUNT write on a tick cycle wins
    for (int i = 0; i < 40 && !(predTick() && !predMatch()); i++) cycle();
    busWrite(32'h04, 32'd5);
    busRead(32'h04, 32'd5, "t6Count");

    // Async reset while a response is pending drops it
    iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = 32'h04; iBUS_BUSY = 1;
    cycle();
    idle();
    inRESET = 0;
    #1;
    modelReset();
    chk("arstReq", 32'(oBUS_REQ), 0);
    chk("arstBusy", 32'(oBUS_BUSY), 0);
    @(posedge iCLOCK); #1;
    inRESET = 1;
    iBUS_BUSY = 0;
    for (int i = 0; i < 3; i++) cycle();
    busRead(32'h08, 32'hFFFF_FFFF, "arstCompare");

    // Sync reset while a response is pending drops it
    busWrite(32'h00, 32'h1);
    iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = 32'h00; iBUS_BUSY = 1;
    cycle();
    idle();
    iRESET_SYNC = 1;
    cycle();
    iRESET_SYNC = 0;
    iBUS_BUSY = 0;
    cycle();
    busRead(32'h00, 32'h0, "srstCtrl");

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      iBUS_REQ    = ($urandom_range(0, 1) == 1);
      iBUS_RW     = ($urandom_range(0, 1) == 1);
      a           = addrTab[$urandom_range(0, 5)];
      iBUS_ADDR   = a | 32'($urandom_range(0, 3));
      case (a)
        32'h00:  iBUS_DATA = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
        32'h04:  iBUS_DATA = 32'($urandom_range(0, 12));
        32'h08:  iBUS_DATA = 32'($urandom_range(0, 12));
        32'h10:  iBUS_DATA = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: iBUS_DATA = $urandom;
      endcase
      iBUS_BUSY   = ($urandom_range(0, 9) < 3);
      iIRQ_ACK    = ($urandom_range(0, 9) == 0);
      iRESET_SYNC = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle();
    iBUS_BUSY = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
